// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter: default widths
// and the fixed requester slot assignment.
package regfile_wb_arbiter_pkg;

  localparam int NREQ_DEFAULT = 3;
  localparam int AW_DEFAULT   = 5;
  localparam int DW_DEFAULT   = 32;

  localparam int WB_PIPE = 0;
  localparam int WB_MDU  = 1;
  localparam int WB_LSU  = 2;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from the request vector
// and a pointer that moves just past the most recent winner.
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_d, ptr_q;
  logic          found;
  int            idx;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_d      = PW'((idx + 1) % NREQ);
      end
    end
    // Nothing may be granted while reset is asserted.
    if (!rst_n) begin
      grant = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back port arbiter: picks one requester per cycle, registers the
// register-file write, and tracks pending writes in a busy scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int AW   = AW_DEFAULT,
  parameter int DW   = DW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               rsv_valid,
  input  logic [AW-1:0]      rsv_addr,
  output logic               we,
  output logic [AW-1:0]      waddr,
  output logic [DW-1:0]      wdata,
  output logic [2**AW-1:0]   busy
);

  logic [NREQ-1:0]  grant;
  logic             xfer;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;
  logic             we_d, we_q;
  logic [AW-1:0]    waddr_d, waddr_q;
  logic [DW-1:0]    wdata_d, wdata_q;
  logic [2**AW-1:0] busy_d, busy_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  // Grant is one-hot or zero, so an AND-OR mux selects the winner's payload.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr = sel_addr | (grant[i] ? req_addr[i*AW +: AW] : '0);
      sel_data = sel_data | (grant[i] ? req_data[i*DW +: DW] : '0);
    end
  end

  always_comb begin
    we_d    = xfer && (sel_addr != '0);
    waddr_d = xfer ? sel_addr : waddr_q;
    wdata_d = xfer ? sel_data : wdata_q;
    busy_d  = busy_q;
    // A reservation beats a retiring write to the same register.
    for (int r = 0; r < 2**AW; r++) begin
      if (r == 0) begin
        busy_d[r] = 1'b0;
      end else if (rsv_valid && (int'(rsv_addr) == r)) begin
        busy_d[r] = 1'b1;
      end else if (we_q && (int'(waddr_q) == r)) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;

endmodule
